// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding selects, load-use/branch/memory-wait stalls and flushes, all combinational from inputs and FSM state.
// Memory-wait FSM holds the whole pipe while the data memory is not ready; a wait longer than TIMEOUT latches a terminal error.
module hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic [4:0]       rdM,
  input  logic [4:0]       rdW,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             loadE,
  input  logic             pcsrcE,
  input  logic             memreqM,
  input  logic             memreadyM,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WC_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              memstall;
  logic              load_use;
  logic [1:0]        fwd_a, fwd_b;

  // Memory stage result wins over writeback: it is the younger write.
  always_comb begin
    fwd_a = 2'b00;
    if (regwriteM && (rdM != 5'd0) && (rdM == rs1E)) begin
      fwd_a = 2'b10;
    end else if (regwriteW && (rdW != 5'd0) && (rdW == rs1E)) begin
      fwd_a = 2'b01;
    end
  end

  always_comb begin
    fwd_b = 2'b00;
    if (regwriteM && (rdM != 5'd0) && (rdM == rs2E)) begin
      fwd_b = 2'b10;
    end else if (regwriteW && (rdW != 5'd0) && (rdW == rs2E)) begin
      fwd_b = 2'b01;
    end
  end

  always_comb begin
    memstall = 1'b0;
    case (state_q)
      RUN:      memstall = memreqM && !memreadyM;
      MEM_WAIT: memstall = !memreadyM;
      ERR:      memstall = 1'b1;
      default:  memstall = 1'b0;
    endcase
  end

  assign load_use = loadE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));

  always_comb begin
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    stallM    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    flushW    = 1'b0;
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (rst) begin
      forwardAE = fwd_a;
      forwardBE = fwd_b;
      if (memstall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
      end else if (pcsrcE) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (load_use) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      RUN: begin
        if (memreqM && !memreadyM) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (memreadyM) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q >= WC_MAX) begin
          state_d   = ERR;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      ERR: begin
        mem_err_d = 1'b1;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Saturate rather than wrap so a long error hold never reads as few stalls.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stallF && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table plus memory-wait, timeout and saturation sequences.
module tb_hazard_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;

  localparam logic [6:0] C_NONE = 7'b0000000; // {stallF,stallD,stallE,stallM,flushD,flushE,flushW}
  localparam logic [6:0] C_LU   = 7'b1100010;
  localparam logic [6:0] C_BR   = 7'b0000110;
  localparam logic [6:0] C_MEM  = 7'b1111001;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       rwM, rwW, loadE, pcsrcE, memreq, memready;
  } in_t;

  typedef struct packed {
    logic [6:0]    ctl;
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic          merr;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic regwriteM, regwriteW, loadE, pcsrcE, memreqM, memreadyM;
  logic stallF, stallD, stallE, stallM, flushD, flushE, flushW;
  logic [1:0] forwardAE, forwardBE;
  logic mem_err;
  logic [CW-1:0] stall_cnt;

  exp_t exp_q[$];
  string name_q[$];
  vec_t tbl[$];
  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_cnt = '0;

  hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .rdM(rdM), .rdW(rdW),
    .regwriteM(regwriteM), .regwriteW(regwriteW), .loadE(loadE), .pcsrcE(pcsrcE),
    .memreqM(memreqM), .memreadyM(memreadyM),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic in_t idle();
    in_t x;
    x = '0;
    x.rst = 1'b1;
    return x;
  endfunction

  function automatic exp_t ex(input logic [6:0] c, input logic [1:0] a, input logic [1:0] b,
                              input logic m);
    exp_t e;
    e = '0;
    e.ctl = c; e.fa = a; e.fb = b; e.merr = m;
    return e;
  endfunction

  task automatic drive(input in_t x);
    rst = x.rst; rs1D = x.rs1D; rs2D = x.rs2D; rs1E = x.rs1E; rs2E = x.rs2E;
    rdE = x.rdE; rdM = x.rdM; rdW = x.rdW; regwriteM = x.rwM; regwriteW = x.rwW;
    loadE = x.loadE; pcsrcE = x.pcsrcE; memreqM = x.memreq; memreadyM = x.memready;
  endtask

  // One cycle: drive after the rising edge, queue the expectation, compare on the falling edge.
  task automatic step(input string nm, input in_t x, input exp_t ein);
    exp_t e, got;
    string n;
    @(posedge clk);
    #1;
    drive(x);
    e = ein;
    e.cnt = exp_cnt;
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (!x.rst) exp_cnt = '0;
    else if (ein.ctl[6] && (exp_cnt != {CW{1'b1}})) exp_cnt = exp_cnt + 1'b1;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty at compare", nm);
    end else begin
      got = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if ({stallF, stallD, stallE, stallM, flushD, flushE, flushW, forwardAE, forwardBE, mem_err}
          !== {got.ctl, got.fa, got.fb, got.merr}) begin
        errors++;
        $display("FAIL %s: ctl=%b fA=%b fB=%b err=%b, expected ctl=%b fA=%b fB=%b err=%b", n,
                 {stallF, stallD, stallE, stallM, flushD, flushE, flushW}, forwardAE, forwardBE,
                 mem_err, got.ctl, got.fa, got.fb, got.merr);
      end
      checks++;
      if (stall_cnt !== got.cnt) begin
        errors++;
        $display("FAIL %s stall_cnt: got %0d, expected %0d", n, stall_cnt, got.cnt);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t t;
    drive(idle());
    rst = 1'b0;
    repeat (2) @(posedge clk);

    t = idle(); t.rst = 1'b0; t.loadE = 1'b1; t.rdE = 5'd5; t.rs1D = 5'd5; t.pcsrcE = 1'b1;
    t.memreq = 1'b1; t.rdM = 5'd3; t.rwM = 1'b1; t.rs1E = 5'd3;
    tbl.push_back('{i: t, e: ex(C_NONE, 2'b00, 2'b00, 1'b0)});
    t = idle();
    tbl.push_back('{i: t, e: ex(C_NONE, 2'b00, 2'b00, 1'b0)});
    t = idle(); t.loadE = 1'b1; t.rdE = 5'd5; t.rs1D = 5'd5;
    tbl.push_back('{i: t, e: ex(C_LU, 2'b00, 2'b00, 1'b0)});
    t = idle(); t.rdE = 5'd5; t.rs1D = 5'd5;
    tbl.push_back('{i: t, e: ex(C_NONE, 2'b00, 2'b00, 1'b0)});
    t = idle(); t.loadE = 1'b1; t.rdE = 5'd7; t.rs2D = 5'd7; t.rs1D = 5'd1;
    tbl.push_back('{i: t, e: ex(C_LU, 2'b00, 2'b00, 1'b0)});
    t = idle(); t.loadE = 1'b1;
    tbl.push_back('{i: t, e: ex(C_NONE, 2'b00, 2'b00, 1'b0)});
    t = idle(); t.rdE = 5'd9; t.rs1D = 5'd9;
    tbl.push_back('{i: t, e: ex(C_NONE, 2'b00, 2'b00, 1'b0)});
    t = idle(); t.rdM = 5'd3; t.rdW = 5'd3; t.rwM = 1'b1; t.rwW = 1'b1; t.rs1E = 5'd3;
    tbl.push_back('{i: t, e: ex(C_NONE, 2'b10, 2'b00, 1'b0)});
    t.rwM = 1'b0;
    tbl.push_back('{i: t, e: ex(C_NONE, 2'b01, 2'b00, 1'b0)});
    t = idle(); t.rdM = 5'd3; t.rwM = 1'b1; t.rdW = 5'd4; t.rwW = 1'b1; t.rs1E = 5'd4; t.rs2E = 5'd3;
    tbl.push_back('{i: t, e: ex(C_NONE, 2'b01, 2'b10, 1'b0)});
    t = idle(); t.rwM = 1'b1; t.rdW = 5'd6; t.rs2E = 5'd6;
    tbl.push_back('{i: t, e: ex(C_NONE, 2'b00, 2'b00, 1'b0)});
    t = idle(); t.pcsrcE = 1'b1; t.loadE = 1'b1; t.rdE = 5'd5; t.rs1D = 5'd5;
    tbl.push_back('{i: t, e: ex(C_BR, 2'b00, 2'b00, 1'b0)});
    t.memreq = 1'b1;
    tbl.push_back('{i: t, e: ex(C_MEM, 2'b00, 2'b00, 1'b0)});
    t = idle(); t.memreq = 1'b1; t.memready = 1'b1;
    tbl.push_back('{i: t, e: ex(C_NONE, 2'b00, 2'b00, 1'b0)});
    t = idle();
    tbl.push_back('{i: t, e: ex(C_NONE, 2'b00, 2'b00, 1'b0)});
    t = idle(); t.memreq = 1'b1; t.memready = 1'b1;
    tbl.push_back('{i: t, e: ex(C_NONE, 2'b00, 2'b00, 1'b0)});

    foreach (tbl[k]) step($sformatf("vec%0d", k), tbl[k].i, tbl[k].e);

    // Three-cycle memory wait, then ready releases in the same cycle.
    t = idle(); t.rst = 1'b0;
    step("wait_rst", t, ex(C_NONE, 2'b00, 2'b00, 1'b0));
    t = idle(); t.memreq = 1'b1;
    for (int n = 0; n < 3; n++) step("wait_stall", t, ex(C_MEM, 2'b00, 2'b00, 1'b0));
    t.memready = 1'b1;
    step("wait_ready", t, ex(C_NONE, 2'b00, 2'b00, 1'b0));
    t = idle();
    step("wait_run", t, ex(C_NONE, 2'b00, 2'b00, 1'b0));
    if (exp_cnt != CW'(3)) begin
      errors++;
      $display("FAIL wait_model: stall count model %0d, expected 3", exp_cnt);
    end

    // Reset in the middle of a wait returns to RUN.
    t = idle(); t.memreq = 1'b1;
    step("midwait_stall", t, ex(C_MEM, 2'b00, 2'b00, 1'b0));
    t = idle(); t.rst = 1'b0;
    step("midwait_rst", t, ex(C_NONE, 2'b00, 2'b00, 1'b0));
    t = idle();
    step("midwait_run", t, ex(C_NONE, 2'b00, 2'b00, 1'b0));

    // Timeout into ERR, then a long hold to saturate the counter.
    t = idle(); t.rst = 1'b0;
    step("to_rst", t, ex(C_NONE, 2'b00, 2'b00, 1'b0));
    t = idle(); t.memreq = 1'b1;
    for (int n = 0; n < TO + 1; n++) step("to_wait", t, ex(C_MEM, 2'b00, 2'b00, 1'b0));
    step("to_err", t, ex(C_MEM, 2'b00, 2'b00, 1'b1));
    t = idle(); t.memready = 1'b1; t.pcsrcE = 1'b1;
    for (int n = 0; n < 16; n++) step("err_hold", t, ex(C_MEM, 2'b00, 2'b00, 1'b1));
    t = idle(); t.rst = 1'b0;
    step("err_rst", t, ex(C_NONE, 2'b00, 2'b00, 1'b1));
    t = idle();
    step("err_cleared", t, ex(C_NONE, 2'b00, 2'b00, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
